// File: rtl/av2wb_pipe.sv
// Avalon-MM pipelined slave to pipelined Wishbone master bridge.
// Up to MAX_OUT transactions in flight, in-order read return, error reporting, watchdog abort/flush.
module av2wb_pipe #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   av_address,
  input  logic [DW-1:0]   av_writedata,
  input  logic [DW/8-1:0] av_byteenable,
  input  logic            av_read,
  input  logic            av_write,
  output logic            av_waitrequest,
  output logic [DW-1:0]   av_readdata,
  output logic            av_readdatavalid,
  output logic [1:0]      av_response,
  output logic [AW-1:0]   wb_adr,
  output logic [DW-1:0]   wb_dat_w,
  output logic [DW/8-1:0] wb_sel,
  output logic            wb_we,
  output logic            wb_cyc,
  output logic            wb_stb,
  input  logic            wb_stall,
  input  logic [DW-1:0]   wb_dat_r,
  input  logic            wb_ack,
  input  logic            wb_err,
  output logic            err_flag,
  input  logic            err_clr
);

  localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW  = $clog2(MAX_OUT) + 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] PMASK = PW'(MAX_OUT - 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]         state;
  logic [CW-1:0]      count;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [MAX_OUT-1:0] tag_rd;
  logic [WDW-1:0]     wd;
  logic req, run, full, busy, issue, retire, flush_pop, pop, pop_is_rd, wd_hit;

  assign req  = av_read | av_write;
  assign run  = (state == ST_RUN);
  assign full = (count == CW'(MAX_OUT));
  assign busy = (count != '0);

  // Commands pass straight through; read+write together is a write.
  assign wb_stb   = req & ~full & run & rst_n;
  assign wb_cyc   = wb_stb | (busy & run);
  assign wb_adr   = av_address;
  assign wb_dat_w = av_writedata;
  assign wb_sel   = av_byteenable;
  assign wb_we    = av_write;

  assign av_waitrequest = (req & (wb_stall | full | ~run)) | ~rst_n;

  assign issue     = wb_stb & ~wb_stall;
  assign retire    = (wb_ack | wb_err) & busy & run;
  assign flush_pop = ~run & busy;
  assign pop       = retire | flush_pop;
  assign pop_is_rd = tag_rd[rd_ptr & PMASK];
  assign wd_hit    = (TIMEOUT != 0) && run && busy && !retire && (wd == WDW'(TIMEOUT - 1));

  // Tag FIFO: one is_read bit per in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_rd <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue) begin
        tag_rd[wr_ptr & PMASK] <= ~av_write;
        wr_ptr                 <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(issue) - CW'(pop);
    end
  end

  // Watchdog and RUN/FLUSH control; FLUSH drains one tag per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd    <= '0;
      state <= ST_RUN;
    end else begin
      if (run && busy && !retire && !wd_hit) wd <= wd + 1'b1;
      else                                   wd <= '0;
      if (wd_hit)                              state <= ST_FLUSH;
      else if (!run && (count <= CW'(1)))      state <= ST_RUN;
    end
  end

  // Read responses are registered one cycle after retire or flush pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      av_readdatavalid <= 1'b0;
      av_readdata      <= '0;
      av_response      <= 2'b00;
    end else begin
      av_readdatavalid <= pop & pop_is_rd;
      if (pop & pop_is_rd) begin
        av_readdata <= (retire & ~wb_err) ? wb_dat_r : '0;
        av_response <= !run ? 2'b11 : (wb_err ? 2'b10 : 2'b00);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     err_flag <= 1'b0;
    else if (wd_hit | (retire & ~pop_is_rd & wb_err)) err_flag <= 1'b1;
    else if (err_clr)                               err_flag <= 1'b0;
  end

endmodule

// File: tb/tb_av2wb_pipe.sv
// Bench for av2wb_pipe: directed Avalon commands, behavioural pipelined WB slave,
// read-response scoreboard checked by an independent monitor.
module tb_av2wb_pipe;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] av_address = '0, av_writedata = '0;
  logic [3:0]  av_byteenable = '0;
  logic        av_read = 1'b0, av_write = 1'b0;
  logic        av_waitrequest, av_readdatavalid;
  logic [31:0] av_readdata;
  logic [1:0]  av_response;
  logic [31:0] wb_adr, wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic        wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
  logic [31:0] wb_dat_r = '0;
  logic        err_flag, err_clr = 1'b0;

  always #5 clk = ~clk;

  av2wb_pipe #(.AW(32), .DW(32), .MAX_OUT(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .av_address(av_address), .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_read(av_read), .av_write(av_write), .av_waitrequest(av_waitrequest),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid), .av_response(av_response),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_stall(wb_stall), .wb_dat_r(wb_dat_r),
    .wb_ack(wb_ack), .wb_err(wb_err), .err_flag(err_flag), .err_clr(err_clr)
  );

  typedef struct {logic [31:0] data; logic [1:0] resp;} exp_t;
  typedef struct {logic [31:0] data; logic err; logic silent; int due;} slv_t;

  exp_t exp_q[$];
  slv_t slv_q[$], pend[$];
  int checks = 0, fails = 0, edge_n = 0;
  int slv_lat = 0, issues = 0, drops = 0, last_rdv = 0, prev_rdv = 0;
  logic [3:0]  last_sel = '0;
  logic [31:0] last_dat = '0;
  bit cyc_watch = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Pipelined WB slave: responses in issue order, slv_lat cycles after issue.
  always @(posedge clk) begin : slave
    slv_t e;
    edge_n++;
    if ((wb_ack || wb_err) && pend.size() != 0) void'(pend.pop_front());
    if (!wb_cyc || !rst_n) pend.delete();
    if (rst_n && wb_cyc && wb_stb && !wb_stall) begin
      if (slv_q.size() != 0) e = slv_q.pop_front();
      else begin e.data = '0; e.err = 1'b0; e.silent = 1'b0; end
      e.due = edge_n + slv_lat;
      pend.push_back(e);
      issues++;
      last_sel = wb_sel;
      last_dat = wb_dat_w;
    end
    #1;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = '0;
    if (pend.size() != 0 && !pend[0].silent && pend[0].due <= edge_n) begin
      wb_ack   = !pend[0].err;
      wb_err   = pend[0].err;
      wb_dat_r = pend[0].data;
    end
  end

  // Monitor: every readdatavalid pops and checks one expected response.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (cyc_watch && pend.size() != 0 && !wb_cyc) drops++;
      if (av_readdatavalid) begin
        prev_rdv = last_rdv;
        last_rdv = edge_n;
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL rd_unexpected: got data %0h resp %0b, none expected", av_readdata, av_response);
        end else begin
          e = exp_q.pop_front();
          chk("rd_rsp", {30'd0, av_response, av_readdata}, {30'd0, e.resp, e.data});
        end
      end
    end
  end

  task automatic slv_push(input logic [31:0] d, input logic err, input logic silent);
    slv_t e;
    e.data = d; e.err = err; e.silent = silent; e.due = 0;
    slv_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge with the command still driven.
  task automatic av_cmd(input logic rd, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [3:0] be, output int waits, output int acc);
    logic w;
    av_read = rd; av_write = ~rd; av_address = adr; av_writedata = wd; av_byteenable = be;
    waits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); w = av_waitrequest;
      @(posedge clk); #1;
      if (!w) begin acc = edge_n; return; end
      waits++;
    end
    checks++; fails++;
    $display("FAIL av_cmd_accept: got waitrequest stuck, want accept within 100 cycles");
    acc = edge_n;
  endtask

  task automatic av_rd(input logic [31:0] adr, input logic [31:0] d, input logic [1:0] r,
                       input bit push, output int waits, output int acc);
    exp_t e;
    av_cmd(1'b1, adr, '0, 4'hf, waits, acc);
    if (push) begin e.data = d; e.resp = r; exp_q.push_back(e); end
  endtask

  task automatic av_idle();
    av_read = 1'b0; av_write = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!wb_cyc && pend.size() == 0 && exp_q.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
    end
    checks++; fails++;
    $display("FAIL %s_idle: got busy, want idle within 300 cycles", name);
    @(posedge clk); #1;
  endtask

  task automatic err_pulse();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int w, a, a1, iss0, drop;
    int wv[5], av[5];

    // Reset state
    #12;
    chk("rst_waitreq", av_waitrequest, 1);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_rdv", av_readdatavalid, 0);
    chk("rst_resp", av_response, 0);
    chk("rst_rdata", av_readdata, 0);
    chk("rst_errflag", err_flag, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read, ack two cycles after strobe
    slv_lat = 1;
    slv_push(32'hDEADBEEF, 1'b0, 1'b0);
    av_rd(32'h1000, 32'hDEADBEEF, 2'b00, 1'b1, w, a);
    av_idle();
    for (int i = 0; i < 20 && !wb_ack; i++) @(negedge clk);
    @(negedge clk);
    chk("single_cyc_drop", wb_cyc, 0);
    wait_idle("single");

    // Four back-to-back reads fill the FIFO, fifth waits
    slv_lat = 8;
    for (int i = 0; i < 5; i++) slv_push(32'(i + 1), 1'b0, 1'b0);
    drops = 0; cyc_watch = 1'b1;
    for (int i = 0; i < 5; i++) av_rd(32'h2000 + 32'(4 * i), 32'(i + 1), 2'b00, 1'b1, wv[i], av[i]);
    av_idle();
    wait_idle("burst");
    cyc_watch = 1'b0;
    chk("burst_consec", av[3] - av[0], 3);
    chk("burst_nowait", wv[0] + wv[1] + wv[2] + wv[3], 0);
    chk("burst_full_waits", wv[4], 6);
    chk("burst_cyc_cont", drops, 0);

    // Stalled write with partial byte select
    slv_lat = 0;
    slv_push('0, 1'b0, 1'b0);
    iss0 = issues;
    wb_stall = 1'b1;
    fork
      av_cmd(1'b0, 32'h3000, 32'hA5A55A5A, 4'b0011, w, a);
      begin repeat (3) @(posedge clk); #1 wb_stall = 1'b0; end
    join
    av_idle();
    wait_idle("stall");
    chk("stall_waits", w, 3);
    chk("stall_issues", issues - iss0, 1);
    chk("stall_sel", last_sel, 4'b0011);
    chk("stall_dat", last_dat, 32'hA5A55A5A);
    chk("stall_errflag", err_flag, 0);

    // Bus errors: read returns SLVERR, write sets sticky flag
    slv_lat = 1;
    slv_push(32'h1234, 1'b1, 1'b0);
    av_rd(32'h4000, 32'h0, 2'b10, 1'b1, w, a);
    av_idle();
    wait_idle("rd_err");
    chk("rd_err_noflag", err_flag, 0);
    slv_push('0, 1'b1, 1'b0);
    av_cmd(1'b0, 32'h4004, 32'hFFFF, 4'hf, w, a);
    av_idle();
    wait_idle("wr_err");
    chk("wr_err_flag", err_flag, 1);
    err_pulse();
    @(negedge clk);
    chk("err_clr", err_flag, 0);
    @(posedge clk); #1;

    // Watchdog: silent slave, abort after 16 cycles, two flushed reads
    slv_push('0, 1'b0, 1'b1);
    slv_push('0, 1'b0, 1'b1);
    av_rd(32'h5000, 32'h0, 2'b11, 1'b1, w, a);
    av_rd(32'h5004, 32'h0, 2'b11, 1'b1, w, a1);
    av_idle();
    drop = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!wb_cyc) begin drop = edge_n; break; end
    end
    chk("wd_cyc_drop", drop - a, 16);
    wait_idle("timeout");
    chk("flush_consec", last_rdv - prev_rdv, 1);
    chk("timeout_errflag", err_flag, 1);
    err_pulse();
    slv_lat = 2;
    slv_push(32'hCAFEF00D, 1'b0, 1'b0);
    av_rd(32'h5008, 32'hCAFEF00D, 2'b00, 1'b1, w, a);
    av_idle();
    wait_idle("post_timeout");

    // Reset with three outstanding reads
    for (int i = 0; i < 3; i++) slv_push('0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) av_rd(32'h6000 + 32'(4 * i), '0, 2'b00, 1'b0, w, a);
    av_idle();
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("midrst_cyc", wb_cyc, 0);
    chk("midrst_waitreq", av_waitrequest, 1);
    slv_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    slv_lat = 1;
    slv_push(32'h0BADF00D, 1'b0, 1'b0);
    av_rd(32'h7000, 32'h0BADF00D, 2'b00, 1'b1, w, a);
    av_idle();
    chk("postrst_nowait", w, 0);
    wait_idle("post_reset");

    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/av2wb_pipe.md
Name: av2wb_pipe

Overview:
- Parametrised Avalon-MM (pipelined, readdatavalid) slave to pipelined Wishbone master bridge; next generation of the single-transaction av2wb used between the Praxos CPU and the system bus.
- Adds configurable widths, up to MAX_OUT in-flight transactions, in-order read return, bus-error reporting and a watchdog timeout with abort/flush.
- Sits between any Avalon-MM master (Praxos core, DMA engines) and a shared Wishbone crossbar port.

Parameters:
AW, 32, address width (byte address, passed through unmodified)
DW, 32, data width; must be a multiple of 8; byteenable/sel width is DW/8
MAX_OUT, 4, max outstanding WB transactions; power of 2, 1..16
TIMEOUT, 1024, cycles without ack/err while outstanding>0 before abort; 0 disables watchdog

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
av_address  in  AW  Avalon byte address
av_writedata  in  DW  write data
av_byteenable  in  DW/8  byte enables
av_read  in  1  read request
av_write  in  1  write request
av_waitrequest  out  1  command not accepted this cycle
av_readdata  out  DW  read data, valid with av_readdatavalid
av_readdatavalid  out  1  one read response, in issue order
av_response  out  2  00 OKAY, 10 SLVERR (bus err), 11 timeout abort; qualified by readdatavalid
wb_adr  out  AW  Wishbone address
wb_dat_w  out  DW  write data
wb_sel  out  DW/8  byte select
wb_we  out  1  write enable
wb_cyc  out  1  cycle
wb_stb  out  1  strobe
wb_stall  in  1  slave stall
wb_dat_r  in  DW  read data
wb_ack  in  1  acknowledge
wb_err  in  1  bus error
err_flag  out  1  sticky: write got wb_err or any timeout occurred
err_clr  in  1  clears err_flag (set wins if same cycle)

Behaviour:
- Reset (async assert, sync release on clk): wb_cyc=wb_stb=0, av_readdatavalid=0, av_response=00, av_readdata=0, err_flag=0, outstanding=0, state IDLE/RUN cleared, tag FIFO empty, watchdog=0. Reset mid-transaction drops wb_cyc immediately; in-flight results discarded.
- Command pass-through is combinational: wb_stb = (av_read|av_write) & ~full & state==RUN; wb_adr/dat_w/sel/we copied from Avalon; wb_we=av_write. av_read&av_write together: treated as write.
- av_waitrequest = (av_read|av_write) & (wb_stall | full | state==FLUSH). Also high while rst_n low.
- Issue = wb_stb & ~wb_stall. On issue push tag {is_read} into MAX_OUT-deep FIFO; full = count==MAX_OUT.
- wb_cyc = wb_stb | (count!=0); held continuously across back-to-back transactions.
- Retire = wb_ack|wb_err with count!=0 (ack with count==0 ignored). Pops tag. If is_read: next cycle av_readdatavalid=1, av_readdata=wb_dat_r (0 on err), av_response=00 ack / 10 err. If write: no Avalon response; wb_err sets err_flag.
- Issue and retire same cycle: count unchanged. Read latency Avalon = WB ack cycle + 1 register.
- Watchdog: counts cycles with count!=0 and no retire; cleared on retire or count==0. On reaching TIMEOUT (TIMEOUT>0): state RUN->FLUSH, wb_cyc=0 next cycle, err_flag set, late ack/err ignored.
- FLUSH: pop one tag per cycle; each read tag produces readdatavalid, readdata=0, response=11. When FIFO empty -> RUN. No new commands accepted in FLUSH.
- count width $clog2(MAX_OUT)+1; no wrap; pushes blocked when full.

Test Plan:
- Single read: WB slave acks 2 cycles after stb with 0xDEADBEEF -> one readdatavalid, data 0xDEADBEEF, response 00, wb_cyc drops the cycle after ack.
- Back-to-back 4 reads, slave zero-stall, acks in order 0x1..0x4 -> 4 issues in 4 consecutive cycles, 5th read waits (full), responses 0x1..0x4 in order, cyc continuous.
- wb_stall high 3 cycles on a write with sel=4'b0011 -> av_waitrequest high 3 cycles, single issue, wb_sel=0011, no readdatavalid.
- Read gets wb_err -> readdatavalid, data 0, response 10; write gets wb_err -> err_flag=1, err_clr pulse -> 0.
- TIMEOUT=16, 2 reads issued, slave silent -> cycle 16 cyc drops, two responses 11 with data 0 on consecutive cycles, err_flag=1, subsequent read completes normally.
- rst_n asserted with 3 outstanding -> wb_cyc=0 asynchronously, no readdatavalid after release, waitrequest low after release.
